// File: rtl/gray_count_monitor_if.sv
// Bus between an 8-bit Gray counter consumer and its environment.
// Carries the sampled count, control strobes and all monitor results.
interface gray_count_monitor_if #(
    parameter int WIDTH   = 8,
    parameter int EPOCH_W = 16
);
    logic [WIDTH-1:0]         gray_in;
    logic                     ovf_in;
    logic                     mon_en;
    logic                     err_clr;
    logic [WIDTH-1:0]         bin_out;
    logic                     bin_valid;
    logic [WIDTH+EPOCH_W-1:0] ext_count;
    logic                     step_err;
    logic                     ovf_err;
    logic [7:0]               err_cnt;

    modport master (
        output gray_in, ovf_in, mon_en, err_clr,
        input  bin_out, bin_valid, ext_count,
        input  step_err, ovf_err, err_cnt
    );

    modport slave (
        input  gray_in, ovf_in, mon_en, err_clr,
        output bin_out, bin_valid, ext_count,
        output step_err, ovf_err, err_cnt
    );
endinterface

// File: rtl/gray_count_monitor.sv
// Gray count monitor: converts a Gray count to binary, extends it with
// a wrap epoch, and checks step/overflow protocol with an error counter.
module gray_count_monitor #(
    parameter int WIDTH   = 8,
    parameter int EPOCH_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    gray_count_monitor_if.slave  bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PRIME = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;

    localparam logic [WIDTH-1:0] MAX = '1;

    logic [1:0]         state;
    logic [WIDTH-1:0]   s1_gray;
    logic               s1_ovf;
    logic [WIDTH-1:0]   bin_q;
    logic               valid_q;
    logic [EPOCH_W-1:0] epoch_q;
    logic               step_q;
    logic               ovf_q;
    logic [7:0]         err_q;

    logic [WIDTH-1:0]   cur;
    logic               is_hold;
    logic               is_step;
    logic               is_wrap;
    logic               is_clear;
    logic               step_bad;
    logic               ovf_bad;
    logic [EPOCH_W-1:0] epoch_nxt;
    logic               run_edge;
    logic               err_now;

    function automatic logic [WIDTH-1:0] g2b(
        input logic [WIDTH-1:0] g
    );
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Classify the stage-1 sample against the current bin_out.
    always_comb begin
        cur       = g2b(s1_gray);
        is_hold   = (cur == bin_q);
        is_wrap   = (bin_q == MAX) && (cur == '0);
        is_step   = (bin_q != MAX) && (cur == bin_q + 1'b1);
        is_clear  = (cur == '0) && (bin_q != '0) && (bin_q != MAX);
        step_bad  = 1'b0;
        ovf_bad   = s1_ovf;
        epoch_nxt = epoch_q;
        unique case (1'b1)
            is_hold:  ovf_bad = s1_ovf;
            is_step:  ovf_bad = s1_ovf;
            is_wrap: begin
                ovf_bad   = ~s1_ovf;
                epoch_nxt = epoch_q + 1'b1;
            end
            is_clear: begin
                ovf_bad   = s1_ovf;
                epoch_nxt = '0;
            end
            default:  step_bad = 1'b1;
        endcase
    end

    assign run_edge = bus.mon_en && (state == RUN);
    assign err_now  = run_edge && (step_bad || ovf_bad);

    // Sequencer: sample stage, binary stage, epoch and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            s1_gray <= '0;
            s1_ovf  <= 1'b0;
            bin_q   <= '0;
            valid_q <= 1'b0;
            epoch_q <= '0;
            step_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (!bus.mon_en) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            step_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            s1_gray <= bus.gray_in;
            s1_ovf  <= bus.ovf_in;
            step_q  <= 1'b0;
            ovf_q   <= 1'b0;
            case (state)
                IDLE: begin
                    state <= PRIME;
                end
                PRIME: begin
                    bin_q   <= cur;
                    valid_q <= 1'b1;
                    epoch_q <= '0;
                    state   <= RUN;
                end
                RUN: begin
                    bin_q   <= cur;
                    valid_q <= 1'b1;
                    epoch_q <= epoch_nxt;
                    step_q  <= step_bad;
                    ovf_q   <= ovf_bad;
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Saturating error counter; a clear beats a same-edge error.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else if (bus.err_clr) begin
            err_q <= '0;
        end else if (err_now && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign bus.bin_out   = bin_q;
    assign bus.bin_valid = valid_q;
    assign bus.ext_count = {epoch_q, bin_q};
    assign bus.step_err  = step_q;
    assign bus.ovf_err   = ovf_q;
    assign bus.err_cnt   = err_q;

endmodule

// File: tb/tb_gray_count_monitor.sv
// Bench for gray_count_monitor: directed protocol scenarios plus a
// randomized phase, all checked against an arithmetic reference model.
module tb_gray_count_monitor;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    gray_count_monitor_if #(.WIDTH(8), .EPOCH_W(16)) bus ();

    gray_count_monitor #(.WIDTH(8), .EPOCH_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    int          m_seen;
    logic [7:0]  m_s1g;
    logic        m_s1o;
    logic [7:0]  m_bin;
    logic        m_valid;
    logic [15:0] m_epoch;
    logic        m_serr;
    logic        m_oerr;
    logic [7:0]  m_err;
    logic [7:0]  last_b;

    function automatic logic [7:0] to_gray(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [7:0] from_gray(input logic [7:0] g);
        logic [7:0] b;
        b = g;
        for (int s = 1; s < 8; s++) b = b ^ (g >> s);
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t",
                   tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [7:0] g, input logic o,
                              input logic en, input logic clr,
                              input logic r);
        logic [7:0] cur;
        logic [7:0] d;
        logic       want;
        logic       legal;
        if (r) begin
            m_seen = 0; m_s1g = 0; m_s1o = 0; m_bin = 0;
            m_valid = 0; m_epoch = 0; m_serr = 0; m_oerr = 0;
            m_err = 0;
            return;
        end
        m_serr = 0;
        m_oerr = 0;
        if (!en) begin
            m_seen  = 0;
            m_valid = 0;
        end else begin
            m_seen = (m_seen < 3) ? m_seen + 1 : 3;
            cur = from_gray(m_s1g);
            if (m_seen == 2) begin
                m_bin = cur; m_valid = 1; m_epoch = 0;
            end else if (m_seen == 3) begin
                d = cur - m_bin;
                legal = 1; want = 0;
                if (d == 0) want = 0;
                else if (d == 1 && m_bin == 8'd255) begin
                    want = 1; m_epoch = m_epoch + 16'd1;
                end else if (d == 1) want = 0;
                else if (cur == 0) m_epoch = 0;
                else legal = 0;
                m_serr = !legal;
                m_oerr = legal ? (m_s1o != want) : m_s1o;
                m_bin = cur; m_valid = 1;
            end
            m_s1g = g;
            m_s1o = o;
        end
        if (clr) m_err = 0;
        else if ((m_serr || m_oerr) && m_err != 8'd255)
            m_err = m_err + 8'd1;
    endtask

    task automatic tick_g(input logic [7:0] g, input logic o,
                          input logic en, input logic clr,
                          input logic r);
        bus.gray_in = g;
        bus.ovf_in  = o;
        bus.mon_en  = en;
        bus.err_clr = clr;
        rst         = r;
        @(posedge clk);
        model_edge(g, o, en, clr, r);
        #1;
        check("bin_out",   bus.bin_out,   m_bin);
        check("bin_valid", bus.bin_valid, m_valid);
        check("ext_count", bus.ext_count, {m_epoch, m_bin});
        check("step_err",  bus.step_err,  m_serr);
        check("ovf_err",   bus.ovf_err,   m_oerr);
        check("err_cnt",   bus.err_cnt,   m_err);
    endtask

    task automatic tick(input logic [7:0] b, input logic o,
                        input logic en, input logic clr,
                        input logic r);
        last_b = b;
        tick_g(to_gray(b), o, en, clr, r);
    endtask

    task automatic step(input logic [7:0] b, input logic o);
        tick(b, o, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int         pulses;
        logic [7:0] held;
        logic [7:0] nb;
        logic [7:0] cb;
        int         pick;
        compared = 0;
        mismatched = 0;
        m_seen = 0; m_s1g = 0; m_s1o = 0; m_bin = 0; m_valid = 0;
        m_epoch = 0; m_serr = 0; m_oerr = 0; m_err = 0; last_b = 0;

        // reset
        tick(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_valid", bus.bin_valid, 0);
        check("rst_ext", bus.ext_count, 0);
        check("rst_errcnt", bus.err_cnt, 0);

        // first samples: valid rises two clocks after the first sample
        step(8'd0, 1'b0);
        check("prime_valid0", bus.bin_valid, 0);
        for (int b = 1; b <= 5; b++) step(8'(b), 1'b0);
        check("first_bin", bus.bin_out, 8'd4);
        step(8'd6, 1'b0);
        check("first_bin5", bus.bin_out, 8'd5);

        // full sweep with a correct overflow at the wrap
        for (int b = 7; b <= 255; b++) step(8'(b), 1'b0);
        step(8'd0, 1'b1);
        check("pre_wrap_ext", bus.ext_count, 24'h0000FF);
        step(8'd1, 1'b0);
        check("wrap_ext", bus.ext_count, 24'h000100);
        check("wrap_ovf_err", bus.ovf_err, 0);
        check("wrap_errcnt", bus.err_cnt, 0);
        step(8'd2, 1'b0);

        // second sweep, overflow missing at the wrap
        for (int b = 3; b <= 255; b++) step(8'(b), 1'b0);
        step(8'd0, 1'b0);
        step(8'd1, 1'b0);
        check("miss_ovf_err", bus.ovf_err, 1);
        check("miss_ovf_cnt", bus.err_cnt, 1);
        step(8'd2, 1'b0);
        check("miss_ovf_pulse", bus.ovf_err, 0);
        tick(8'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        check("clr_errcnt", bus.err_cnt, 0);

        // upstream clear, then a skip 5 -> 7
        for (int b = 3; b <= 10; b++) step(8'(b), 1'b0);
        step(8'd0, 1'b0);
        step(8'd0, 1'b0);
        check("clear_ext", bus.ext_count, 0);
        check("clear_step_err", bus.step_err, 0);
        for (int b = 1; b <= 5; b++) step(8'(b), 1'b0);
        step(8'd7, 1'b0);
        step(8'd7, 1'b0);
        check("skip_bin", bus.bin_out, 8'd7);
        check("skip_step_err", bus.step_err, 1);
        check("skip_errcnt", bus.err_cnt, 1);

        // hold with a spurious overflow on the second sample
        pulses = 0;
        step(8'd7, 1'b1);
        pulses += int'(bus.ovf_err);
        step(8'd7, 1'b0);
        pulses += int'(bus.ovf_err);
        step(8'd7, 1'b0);
        pulses += int'(bus.ovf_err);
        step(8'd7, 1'b0);
        pulses += int'(bus.ovf_err);
        check("hold_ovf_pulses", pulses, 1);
        check("hold_errcnt", bus.err_cnt, 2);

        // clear beats a same-edge error
        tick(8'd20, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(8'd20, 1'b0, 1'b1, 1'b1, 1'b0);
        check("clr_vs_err_step", bus.step_err, 1);
        check("clr_vs_err_cnt", bus.err_cnt, 0);

        // 300 illegal transitions saturate the counter
        for (int k = 0; k < 300; k++) begin
            do nb = 8'($urandom_range(255));
            while (nb == last_b || nb == last_b + 8'd1 || nb == 8'd0);
            step(nb, 1'b0);
        end
        step(last_b, 1'b0);
        check("sat_errcnt", bus.err_cnt, 8'd255);

        // monitor disabled: outputs hold, valid drops
        held = m_bin;
        tick(8'd99, 1'b0, 1'b0, 1'b0, 1'b0);
        check("dis_valid", bus.bin_valid, 0);
        check("dis_bin", bus.bin_out, held);
        check("dis_errcnt", bus.err_cnt, 8'd255);
        tick(8'd98, 1'b1, 1'b0, 1'b0, 1'b0);

        // reset in the middle of a sweep
        for (int b = 0; b <= 8'h37; b++) step(8'(b), 1'b0);
        tick(8'h38, 1'b0, 1'b1, 1'b0, 1'b1);
        check("midrst_valid", bus.bin_valid, 0);
        check("midrst_ext", bus.ext_count, 0);
        check("midrst_errcnt", bus.err_cnt, 0);
        step(8'h39, 1'b0);
        check("midrst_idle", bus.bin_valid, 0);

        // randomized traffic
        cb = 8'd0;
        for (int k = 0; k < 3000; k++) begin
            pick = int'($urandom_range(99));
            if (pick < 80) cb = cb + 8'd1;
            else if (pick < 88) cb = cb;
            else if (pick < 94) cb = 8'($urandom_range(255));
            else cb = 8'd0;
            tick(cb,
                 ($urandom_range(99) < 10) ? 1'b1 : (cb == 8'd0),
                 $urandom_range(99) < 96,
                 $urandom_range(99) < 3,
                 $urandom_range(999) < 4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
